// File: rtl/mux_scan_pkg.sv
// Shared encodings for the scanning channel multiplexer.
// Holds the FSM state type, mode constants and small elaboration helpers.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic state_t next_state(input logic en, input logic mode);
        if (!en) return IDLE;
        return (mode == MODE_SCAN) ? SCAN : DIRECT;
    endfunction

endpackage

// File: rtl/mux_scan_nto1.sv
// Combinational N_CH:1 channel selector.
// Select values with no matching channel return all zeros.
module mux_nto1
    import mux_scan_pkg::*;
#(
    parameter int N_CH = 16,
    parameter int W    = 1,
    localparam int CW  = ch_width(N_CH)
) (
    input  logic [N_CH*W-1:0] in,
    input  logic [CW-1:0]     sel,
    output logic [W-1:0]      out
);

    always_comb begin
        out = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == CW'(k)) out = in[k*W +: W];
        end
    end

endmodule

// File: rtl/mux_scan.sv
// Channel multiplexer with a direct-select mode and a timed round-robin scan mode,
// driving a single registered valid/ready output slot.
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter int N_CH  = 16,
    parameter int W     = 1,
    parameter int DWELL = 4,
    localparam int CW   = ch_width(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*W-1:0] in,
    input  logic [CW-1:0]     sel,
    input  logic              mode,
    input  logic              en,
    output logic [W-1:0]      out,
    output logic [CW-1:0]     out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              scan_wrap
);

    localparam int DW                 = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DW_LAST = DW'(DWELL - 1);
    localparam logic [CW-1:0] CH_LAST = CW'(N_CH - 1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   ch;
    logic [CW-1:0]   mux_sel;
    logic [DW-1:0]   dwell_cnt;
    logic [W-1:0]    mux_out;
    logic            slot_free;
    logic            dir_load;
    logic            scan_load;

    assign state_nxt = next_state(en, mode);
    assign slot_free = !out_valid || out_ready;
    assign dir_load  = (state == DIRECT) && slot_free;
    assign scan_load = (state == SCAN) && (dwell_cnt == DW_LAST) && slot_free;
    assign mux_sel   = (state == SCAN) ? ch : sel;

    mux_nto1 #(.N_CH(N_CH), .W(W)) u_mux (
        .in  (in),
        .sel (mux_sel),
        .out (mux_out)
    );

    // Actions follow the registered state, so a mode/en change lands one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out       <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            scan_wrap <= 1'b0;
            ch        <= '0;
            dwell_cnt <= '0;
        end else begin
            state     <= state_nxt;
            scan_wrap <= scan_load && (ch == CH_LAST);

            if (dir_load || scan_load) begin
                out       <= mux_out;
                out_ch    <= mux_sel;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (state_nxt == SCAN && state != SCAN) begin
                ch        <= '0;
                dwell_cnt <= '0;
            end else if (state == SCAN) begin
                if (dwell_cnt != DW_LAST) begin
                    dwell_cnt <= dwell_cnt + 1'b1;
                end else if (slot_free) begin
                    // A blocked slot parks the scan here, so no channel is skipped.
                    dwell_cnt <= '0;
                    ch        <= (ch == CH_LAST) ? '0 : ch + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_scan.sv
// Directed bench for mux_scan: a 16-channel DWELL=4 instance and a 12-channel DWELL=1 instance.
// Expected beats are queued when stimulus is applied and popped as the DUT presents them.
module tb_mux_scan;
    import mux_scan_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_mode, a_en, a_rdy;
    logic [15:0] a_in;
    logic [3:0]  a_sel;
    logic [0:0]  a_out;
    logic [3:0]  a_ch;
    logic        a_vld, a_wrap;

    logic        b_rst, b_mode, b_en, b_rdy;
    logic [11:0] b_in;
    logic [3:0]  b_sel;
    logic [0:0]  b_out;
    logic [3:0]  b_ch;
    logic        b_vld, b_wrap;

    mux_scan #(.N_CH(16), .W(1), .DWELL(4)) u_a (
        .clk(clk), .rst(a_rst), .in(a_in), .sel(a_sel), .mode(a_mode), .en(a_en),
        .out(a_out), .out_ch(a_ch), .out_valid(a_vld), .out_ready(a_rdy), .scan_wrap(a_wrap)
    );

    mux_scan #(.N_CH(12), .W(1), .DWELL(1)) u_b (
        .clk(clk), .rst(b_rst), .in(b_in), .sel(b_sel), .mode(b_mode), .en(b_en),
        .out(b_out), .out_ch(b_ch), .out_valid(b_vld), .out_ready(b_rdy), .scan_wrap(b_wrap)
    );

    typedef struct {
        logic [3:0] ch;
        logic       d;
    } beat_t;

    beat_t sb[$];
    int    total = 0;
    int    bad   = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic vld, input logic [3:0] ch, input logic d);
        beat_t b;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s: scoreboard empty, got ch %0h", tag, ch);
        end else begin
            b = sb.pop_front();
            chk({tag, " vld"}, 32'(vld), 32'd1);
            chk({tag, " ch"},  32'(ch),  32'(b.ch));
            chk({tag, " out"}, 32'(d),   32'(b.d));
        end
    endtask

    initial begin
        // Reset overrides an enabled scan request.
        a_rst = 1'b1; a_en = 1'b1; a_mode = MODE_SCAN; a_rdy = 1'b0;
        a_in = 16'hAAAA; a_sel = 4'd9;
        b_rst = 1'b1; b_en = 1'b0; b_mode = MODE_DIRECT; b_rdy = 1'b1;
        b_in = 12'hABC; b_sel = 4'd0;
        cyc(); cyc();
        chk("rst out",  32'(a_out),  32'd0);
        chk("rst ch",   32'(a_ch),   32'd0);
        chk("rst vld",  32'(a_vld),  32'd0);
        chk("rst wrap", 32'(a_wrap), 32'd0);

        // Direct sweep: out follows in[sel] one cycle later.
        a_rst = 1'b0; a_mode = MODE_DIRECT; a_rdy = 1'b1; a_sel = 4'd0;
        cyc();
        chk("dir first vld", 32'(a_vld), 32'd0);
        for (int k = 0; k < 16; k++) begin
            a_sel = 4'(k);
            sb.push_back('{4'(k), a_in[k]});
            cyc();
            chk_beat("dir sweep", a_vld, a_ch, a_out[0]);
        end

        // Backpressure holds the beat and ignores sel.
        a_rdy = 1'b0; a_sel = 4'd3;
        cyc();
        chk("bp hold ch",  32'(a_ch),  32'd15);
        chk("bp hold vld", 32'(a_vld), 32'd1);
        a_sel = 4'd9;
        cyc();
        chk("bp hold ch2", 32'(a_ch),  32'd15);
        chk("bp hold out", 32'(a_out), 32'd1);
        a_rdy = 1'b1; a_sel = 4'd6;
        cyc();
        chk("bp release ch",  32'(a_ch),  32'd6);
        chk("bp release out", 32'(a_out), 32'd0);

        // Scan: entry edge still performs the last direct load.
        a_mode = MODE_SCAN;
        cyc();
        chk("scan entry ch", 32'(a_ch), 32'd6);
        for (int k = 0; k < 20; k++) sb.push_back('{4'(k % 16), a_in[k % 16]});
        for (int c = 1; c <= 80; c++) begin
            cyc();
            if (c % 4 == 0) begin
                chk("scan wrap", 32'(a_wrap), 32'(((c / 4 - 1) % 16) == 15));
                chk_beat("scan beat", a_vld, a_ch, a_out[0]);
            end else begin
                chk("scan gap vld",  32'(a_vld),  32'd0);
                chk("scan gap wrap", 32'(a_wrap), 32'd0);
            end
        end

        // Stall for 10 cycles after the channel-3 beat.
        a_rdy = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            chk("stall vld", 32'(a_vld), 32'd1);
            chk("stall ch",  32'(a_ch),  32'd3);
        end
        sb.push_back('{4'd4, a_in[4]});
        a_rdy = 1'b1;
        cyc();
        chk_beat("stall next", a_vld, a_ch, a_out[0]);
        for (int k = 5; k <= 7; k++) sb.push_back('{4'(k), a_in[k]});
        for (int c = 92; c <= 103; c++) begin
            cyc();
            if ((c - 91) % 4 == 0) chk_beat("post stall", a_vld, a_ch, a_out[0]);
            else chk("post stall gap", 32'(a_vld), 32'd0);
        end

        // Reset with the channel-7 beat pending.
        a_rdy = 1'b0; a_rst = 1'b1;
        cyc();
        chk("midrst out",  32'(a_out),  32'd0);
        chk("midrst ch",   32'(a_ch),   32'd0);
        chk("midrst vld",  32'(a_vld),  32'd0);
        chk("midrst wrap", 32'(a_wrap), 32'd0);
        a_rst = 1'b0; a_rdy = 1'b1;
        cyc();
        chk("rescan entry vld", 32'(a_vld), 32'd0);
        sb.push_back('{4'd0, a_in[0]});
        sb.push_back('{4'd1, a_in[1]});
        for (int c = 1; c <= 8; c++) begin
            cyc();
            if (c % 4 == 0) chk_beat("rescan beat", a_vld, a_ch, a_out[0]);
            else chk("rescan gap", 32'(a_vld), 32'd0);
        end
        a_en = 1'b0;

        // 12 channels: out-of-range select, then idle with a pending beat.
        b_rst = 1'b0; b_en = 1'b1; b_sel = 4'd13;
        cyc();
        chk("b first vld", 32'(b_vld), 32'd0);
        cyc();
        chk("b oor out", 32'(b_out), 32'd0);
        chk("b oor ch",  32'(b_ch),  32'd13);
        chk("b oor vld", 32'(b_vld), 32'd1);
        b_sel = 4'd11;
        cyc();
        chk("b ch11 ch",  32'(b_ch),  32'd11);
        chk("b ch11 out", 32'(b_out), 32'(b_in[11]));
        b_rdy = 1'b0; b_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("b idle hold vld", 32'(b_vld), 32'd1);
            chk("b idle hold ch",  32'(b_ch),  32'd11);
        end
        b_rdy = 1'b1;
        cyc();
        chk("b idle drop vld", 32'(b_vld), 32'd0);
        chk("b idle keep ch",  32'(b_ch),  32'd11);
        chk("b idle keep out", 32'(b_out), 32'(b_in[11]));

        // DWELL=1 scan: one beat per cycle, wrap on channel 11.
        b_en = 1'b1; b_mode = MODE_SCAN;
        cyc();
        for (int k = 0; k <= 12; k++) sb.push_back('{4'(k % 12), b_in[k % 12]});
        for (int c = 0; c <= 12; c++) begin
            cyc();
            chk("b scan wrap", 32'(b_wrap), 32'(c == 11));
            chk_beat("b scan beat", b_vld, b_ch, b_out[0]);
        end
        chk("sb drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 Parameter N_CH, default 16: number of input channels, legal range 2..256.
REQ-002 Parameter W, default 1: width of each channel in bits.
REQ-003 Parameter DWELL, default 4: clock cycles spent on each channel in scan mode, legal range >=1.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port in, input, N_CH*W: packed channel data; channel k occupies bits [k*W+W-1:k*W].
REQ-007 Port sel, input, CW = max(1,$clog2(N_CH)): channel select in direct mode.
REQ-008 Port mode, input, 1: 0 = direct, 1 = scan.
REQ-009 Port en, input, 1: block enable.
REQ-010 Port out, output, W: registered selected data.
REQ-011 Port out_ch, output, CW: channel index of the current out beat.
REQ-012 Port out_valid, output, 1: out/out_ch hold a beat not yet accepted.
REQ-013 Port out_ready, input, 1: downstream accepts the beat when out_valid and out_ready are both 1 in the same cycle.
REQ-014 Port scan_wrap, output, 1: one-cycle pulse when scan captures channel N_CH-1.

Function
REQ-015 FSM states are IDLE, DIRECT and SCAN; next state is computed each cycle from en and mode (en=0 -> IDLE; en=1, mode=0 -> DIRECT; en=1, mode=1 -> SCAN).
REQ-016 The output slot is free when out_valid=0 or out_ready=1; loading and acceptance in the same cycle replaces the beat with no bubble.
REQ-017 DIRECT: each cycle the slot is free, the block loads out<=in[sel] and out_ch<=sel and sets out_valid=1; latency is 1 cycle from sel/in to out.
REQ-018 DIRECT with backpressure: while out_valid=1 and out_ready=0, out and out_ch hold and sel changes are ignored.
REQ-019 SCAN entry from any other state sets ch=0 and dwell_cnt=0.
REQ-020 SCAN: dwell_cnt increments each cycle up to DWELL-1; at DWELL-1 with the slot free it loads out<=in[ch] and out_ch<=ch, sets out_valid=1, zeroes dwell_cnt and advances ch.
REQ-021 SCAN stall: at dwell_cnt=DWELL-1 with the slot not free, dwell_cnt and ch hold until the slot frees; no channel is skipped.
REQ-022 ch wraps from N_CH-1 to 0; scan_wrap=1 in exactly the cycle out_ch becomes N_CH-1 via scan load.
REQ-023 With DWELL=1 and out_ready=1, SCAN produces one beat per cycle.
REQ-024 IDLE: no new loads; a pending beat (out_valid=1) stays until accepted, then out_valid=0; out and out_ch keep their last values.
REQ-025 sel >= N_CH (non-power-of-2 N_CH): the loaded out is all zeros and out_ch=sel.
REQ-026 A mode change while en=1 takes effect on the next cycle; a pending beat is not dropped.

Reset
REQ-027 rst=1 at a clock edge forces state=IDLE, out=0, out_ch=0, out_valid=0, scan_wrap=0, ch=0 and dwell_cnt=0, regardless of any other input.
REQ-028 Reset mid-scan or mid-handshake discards the pending beat; operation resumes per REQ-015 on the first cycle after rst=0.

Structure
REQ-029 A shared package mux_scan_pkg holds the state encoding (IDLE=2'd0, DIRECT=2'd1, SCAN=2'd2) and the mode constants MODE_DIRECT=0 and MODE_SCAN=1.
REQ-030 The combinational N_CH:1 selector, including the out-of-range zeroing, is a sub-module mux_nto1 (parameters N_CH, W) instantiated once; mux_scan holds all sequential logic.

Verification
REQ-031 N_CH=16, W=1, in=16'hAAAA, en=1, mode=0, out_ready=1, sel swept 0..15 one per cycle -> out one cycle later follows 0,1,0,1,...; out_ch=sel delayed by 1 cycle.
REQ-032 Scan mode, DWELL=4, out_ready=1, in=16'hAAAA -> one beat every 4 cycles, out_ch 0..15 then 0, scan_wrap pulses once per 64 cycles on out_ch=15.
REQ-033 Scan mode, out_ready held 0 for 10 cycles after the beat for channel 3 -> out_ch=3 holds, next beat is channel 4, no channel skipped.
REQ-034 rst=1 for 1 cycle during scan at ch=7 with out_valid=1 -> all outputs 0 next cycle; scan restarts at ch=0.
REQ-035 N_CH=12, direct mode, sel=13 -> out=0, out_ch=13; en dropped with a pending beat -> out_valid holds until out_ready=1.
